// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// default latencies and the controller state type.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    function automatic logic isDiv(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isMulDiv(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || isDiv(op);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide result generator. Produces {hi,lo}
// for the selected op and flags a zero divisor.
module md_arith
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] resHi,
    output logic [31:0] resLo,
    output logic        divByZero
);

    logic [63:0] signedProd;
    logic [63:0] unsignedProd;
    logic        signedDiv;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] divisor;
    logic [31:0] magQuot;
    logic [31:0] magRem;
    logic        negQuot;
    logic        negRem;

    assign signedProd   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign unsignedProd = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly and the
    // remainder naturally follows the dividend's sign.
    assign signedDiv = (op == MD_DIV);
    assign absA      = (signedDiv && a[31]) ? (32'd0 - a) : a;
    assign absB      = (signedDiv && b[31]) ? (32'd0 - b) : b;
    assign divisor   = (b == 32'd0) ? 32'd1 : absB;
    assign magQuot   = absA / divisor;
    assign magRem    = absA % divisor;
    assign negQuot   = signedDiv && (a[31] ^ b[31]);
    assign negRem    = signedDiv && a[31];

    always_comb begin
        resHi     = 32'd0;
        resLo     = 32'd0;
        divByZero = 1'b0;
        case (op)
            MD_MULT: begin
                resHi = signedProd[63:32];
                resLo = signedProd[31:0];
            end
            MD_MULTU: begin
                resHi = unsignedProd[63:32];
                resLo = unsignedProd[31:0];
            end
            MD_DIV, MD_DIVU: begin
                resLo     = negQuot ? (32'd0 - magQuot) : magQuot;
                resHi     = negRem  ? (32'd0 - magRem)  : magRem;
                divByZero = (b == 32'd0);
            end
            default: begin
                resHi = 32'd0;
                resLo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide resource controller: latches the result at issue, holds
// busy for a fixed latency, then commits to HI/LO. Also handles MTHI/MTLO.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pendHi_q;
    logic [31:0] pendLo_q;
    logic        pendDbz_q;

    md_op_e      opIn;
    logic [31:0] arithHi_d;
    logic [31:0] arithLo_d;
    logic        arithDbz_d;

    assign opIn = md_op_e'(md_op);

    md_arith u_arith (
        .op        (opIn),
        .a         (a),
        .b         (b),
        .resHi     (arithHi_d),
        .resLo     (arithLo_d),
        .divByZero (arithDbz_d)
    );

    // Cancel beats both a same-cycle start and a same-cycle completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pendHi_q  <= 32'd0;
            pendLo_q  <= 32'd0;
            pendDbz_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        if (isMulDiv(opIn)) begin
                            pendHi_q  <= arithHi_d;
                            pendLo_q  <= arithLo_d;
                            pendDbz_q <= arithDbz_d;
                            cnt_q     <= isDiv(opIn) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            busy_q    <= 1'b1;
                            state_q   <= ST_RUN;
                        end else if (opIn == MD_MTHI) begin
                            hi_q <= a;
                        end else if (opIn == MD_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd1) begin
                        if (!pendDbz_q) begin
                            hi_q <= pendHi_q;
                            lo_q <= pendLo_q;
                        end
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
